// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // Must track the data_width of the async FIFO this arbiter feeds.
    localparam int FIFO_DATA_WIDTH = 16;
    localparam int DEF_MAX_BURST   = 8;
    localparam int STAT_W          = 16;

    // Beat counter holds 0..MAX_BURST without wrapping.
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after last_served, with wrap.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; found is low when no request is set.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_served,
    output logic               found,
    output logic [IDX_W-1:0]   next_idx
);

    // cand[k] is the requester at distance k+1 from the last one served.
    logic [IDX_W-1:0] cand [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
        assign cand[k] = IDX_W'((int'(last_served) + k + 1) % NUM_REQ);
    end

    // Scan farthest-first so the nearest requesting candidate is the final winner.
    always_comb begin
        found    = 1'b0;
        next_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                found    = 1'b1;
                next_idx = cand[k];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ burst requesters; optional FIFO_ARB_STATS_EN adds per-requester beat counters.
// Latency: 1 idle arbitration cycle per grant, then beats pass combinationally to w_valid/w_data.
// Backpressure: full stalls the owner (no ready, no write) indefinitely; the grant is held until last beat or MAX_BURST beats.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk_wr,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          w_valid,
    output logic [DATA_WIDTH-1:0]         w_data,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          busy
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                          stats_clr,
    output logic [NUM_REQ*STAT_W-1:0]     beat_cnt
`endif
);

    localparam int CNT_W = cnt_width(MAX_BURST);

    arb_state_t            state;
    logic [IDX_W-1:0]      last_served;
    logic [CNT_W-1:0]      burst_cnt;
    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;
    logic                  beat;
    logic                  release_grant;
    logic [DATA_WIDTH-1:0] req_slice [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign req_slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req         (req_valid),
        .last_served (last_served),
        .found       (pick_found),
        .next_idx    (pick_idx)
    );

    // Only the owner's valid feeds the beat, so other requesters never reach any ready.
    assign beat          = (state == ARB_BURST) && req_valid[grant_id] && !full;
    assign release_grant = beat && (req_last[grant_id] || (burst_cnt == CNT_W'(MAX_BURST - 1)));
    assign w_valid       = beat;

    // Route the owner's ready and data only on an accepted beat; otherwise everything is zero.
    always_comb begin
        req_ready = '0;
        w_data    = '0;
        if (beat) begin
            req_ready[grant_id] = 1'b1;
            w_data              = req_slice[grant_id];
        end
    end

    // Arbitration FSM: pick in IDLE, hold the grant through the burst, release on last or MAX_BURST.
    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            grant_id    <= '0;
            last_served <= IDX_W'(NUM_REQ - 1);
            burst_cnt   <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant_id  <= pick_idx;
                        burst_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= ARB_BURST;
                    end
                end
                ARB_BURST: begin
                    if (release_grant) begin
                        last_served <= grant_id;
                        burst_cnt   <= '0;
                        busy        <= 1'b0;
                        state       <= ARB_IDLE;
                    end else if (beat) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
        logic [STAT_W-1:0] cnt;

        // Saturating count of beats accepted from requester i; clear wins over increment.
        always_ff @(posedge clk_wr or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (stats_clr) begin
                cnt <= '0;
            end else if (req_ready[i] && (cnt != {STAT_W{1'b1}})) begin
                cnt <= cnt + STAT_W'(1);
            end
        end

        assign beat_cnt[i*STAT_W +: STAT_W] = cnt;
    end
`endif

endmodule
